issue_queue: RTL and testbench
==============================

// Module: issue_queue
// PURPOSE
//  Unified out-of-order issue queue directly downstream of rename. Accepts up to 4
//  renamed uops per cycle, holds them until both source pregs are ready (writeback
//  wakeup), then issues the oldest ready uop, one per cycle, through a registered
//  valid/ready output stage to the execute units.
// PARAMETERS
//  DEPTH               16  number of queue entries (>= DISPATCH_WIDTH)
//  DISPATCH_WIDTH      4   enqueue slots per cycle
//  WB_WIDTH            4   writeback wakeup ports per cycle
//  PHY_REG_ADDR_WIDTH  6   physical register index width
//  PAYLOAD_W           64  opaque uop payload (fu type, imm, rob idx, ...), carried untouched
// PORTS
//  clk_i           in   1                     clock, rising edge
//  rst_i           in   1                     asynchronous reset, active-high
//  flush_i         in   1                     pipeline flush, synchronous
//  enq_valid_i     in   DISPATCH_WIDTH        per-slot uop valid from rename
//  enq_rs1_preg_i  in   DISPATCH_WIDTH*PRW    source 1 preg per slot
//  enq_rs2_preg_i  in   DISPATCH_WIDTH*PRW    source 2 preg per slot
//  enq_rd_preg_i   in   DISPATCH_WIDTH*PRW    destination preg per slot
//  enq_rs1_rdy_i   in   DISPATCH_WIDTH        source 1 already ready (busy table)
//  enq_rs2_rdy_i   in   DISPATCH_WIDTH        source 2 already ready (busy table)
//  enq_payload_i   in   DISPATCH_WIDTH*PAYLOAD_W  payload per slot
//  enq_ready_o     out  1                     queue can accept a full group this cycle
//  wb_valid_i      in   WB_WIDTH              writeback wakeup valid
//  wb_preg_i       in   WB_WIDTH*PRW          woken preg per port
//  iss_valid_o     out  1                     issue output register holds a uop
//  iss_ready_i     in   1                     execute accepts the uop
//  iss_rs1_preg_o  out  PRW                   issued source 1 preg
//  iss_rs2_preg_o  out  PRW                   issued source 2 preg
//  iss_rd_preg_o   out  PRW                   issued destination preg
//  iss_payload_o   out  PAYLOAD_W             issued payload
// BEHAVIOUR
//  Reset (rst_i=1, async): all entries invalid, count=0, age matrix cleared,
//   iss_valid_o=0, iss_*_preg_o=0, iss_payload_o=0; enq_ready_o=1 once count=0 is visible.
//  Entry state: valid, rs1_rdy, rs2_rdy, pregs, payload; age matrix older[i][j].
//  enq_ready_o = (DEPTH - count) >= DISPATCH_WIDTH, from registered count only (no
//   combinational path from enq_valid_i). Group enqueue is all-or-nothing:
//   slot k written iff enq_valid_i[k] && enq_ready_o. Holes in enq_valid_i allowed.
//  Allocation: valid slots fill lowest-index free entries in slot order; program
//   order = slot order; new entries are younger than every resident entry and than
//   lower slots of the same group.
//  Source readiness at enqueue: rdy = enq_rsX_rdy_i | (preg==0) | match on any
//   wb_valid_i/wb_preg_i in the same cycle (same-cycle wakeup is never lost).
//  Wakeup: each cycle every valid entry sets rsX_rdy when rsX_preg equals any valid
//   wb_preg_i; visible for select the following cycle.
//  Select: an entry is eligible when valid && rs1_rdy && rs2_rdy. Oldest eligible is
//   chosen via the age matrix, combinationally from registered state.
//  Output stage: load = ~iss_valid_o | iss_ready_i. If load && an eligible entry
//   exists, selected entry moves into output regs and is freed at the same edge.
//   If load && none eligible, iss_valid_o goes 0. Otherwise outputs hold stable
//   (valid/ready: data never changes while iss_valid_o && !iss_ready_i).
//  Latency: uop enqueued ready in cycle N -> iss_valid_o in N+2 (empty queue, idle output).
//   Back-to-back: one issue per cycle sustained while iss_ready_i=1.
//  count_next = count + enqueued - dequeued; simultaneous enqueue and dequeue allowed,
//   freed entry reusable only from the next cycle.
//  Full: count > DEPTH-DISPATCH_WIDTH -> enq_ready_o=0; inputs ignored, no overwrite.
//  Empty: no eligible entry -> no spurious issue; iss_valid_o only by load rule.
//  Flush: at the edge where flush_i=1 all entries, count, age matrix and iss_valid_o
//   clear; flush dominates same-cycle enqueue, wakeup and issue handshake.
//  Reset mid-operation: asynchronous return to reset state regardless of handshake.
//  Wakeup of a preg not present in any entry has no effect.
// TESTING
//  1. Reset, enqueue 1 uop rs1=5,rs2=6 both rdy, iss_ready_i=1 -> iss_valid_o=1 exactly
//     2 cycles later with rs1=5,rs2=6, queue count back to 0.
//  2. Enqueue A(rs1=7 not rdy) then B(all rdy) next cycle; wb_preg=7 two cycles later
//     -> B issues first, A issues the cycle after wakeup is visible.
//  3. Enqueue slot0 rs1=9 not rdy with wb_valid=1,wb_preg=9 in same cycle -> entry
//     issues with no further wakeup required.
//  4. iss_ready_i=0, fill 4 groups of 4 (DEPTH=16) -> enq_ready_o drops to 0 after
//     count>12; extra valid group ignored; output payload held stable for 10 cycles.
//  5. Three ready uops enqueued in slots 2,0,1 order of age -> issue order matches slot
//     order 0,1,2 within the group, older group always first.
//  6. Queue holding 8 uops, iss_valid_o=1, flush_i=1 with enq_valid_i=4'hF -> next cycle
//     iss_valid_o=0, count=0, enq_ready_o=1, no flushed uop ever issues.

Source files
------------

// File: rtl/issue_queue.sv
// issue_queue: out-of-order issue queue with wakeup, age-matrix oldest-ready select and a registered issue stage
module issue_queue #(
    parameter int DEPTH              = 16,
    parameter int DISPATCH_WIDTH     = 4,
    parameter int WB_WIDTH           = 4,
    parameter int PHY_REG_ADDR_WIDTH = 6,
    parameter int PAYLOAD_W          = 64
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    flush_i,
    input  logic [DISPATCH_WIDTH-1:0]               enq_valid_i,
    input  logic [DISPATCH_WIDTH*PHY_REG_ADDR_WIDTH-1:0] enq_rs1_preg_i,
    input  logic [DISPATCH_WIDTH*PHY_REG_ADDR_WIDTH-1:0] enq_rs2_preg_i,
    input  logic [DISPATCH_WIDTH*PHY_REG_ADDR_WIDTH-1:0] enq_rd_preg_i,
    input  logic [DISPATCH_WIDTH-1:0]               enq_rs1_rdy_i,
    input  logic [DISPATCH_WIDTH-1:0]               enq_rs2_rdy_i,
    input  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0]     enq_payload_i,
    output logic                                    enq_ready_o,
    input  logic [WB_WIDTH-1:0]                     wb_valid_i,
    input  logic [WB_WIDTH*PHY_REG_ADDR_WIDTH-1:0]  wb_preg_i,
    output logic                                    iss_valid_o,
    input  logic                                    iss_ready_i,
    output logic [PHY_REG_ADDR_WIDTH-1:0]           iss_rs1_preg_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0]           iss_rs2_preg_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0]           iss_rd_preg_o,
    output logic [PAYLOAD_W-1:0]                    iss_payload_o
);
    localparam int DW  = DISPATCH_WIDTH;
    localparam int PRW = PHY_REG_ADDR_WIDTH;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int SW  = (DW > 1) ? $clog2(DW) : 1;

    logic [DEPTH-1:0]     r_valid, r_rs1_rdy, r_rs2_rdy;
    logic [PRW-1:0]       r_rs1 [DEPTH];
    logic [PRW-1:0]       r_rs2 [DEPTH];
    logic [PRW-1:0]       r_rd [DEPTH];
    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [DEPTH-1:0]     r_older [DEPTH];
    logic [CW-1:0]        r_count;
    logic                 r_iss_valid;
    logic [PRW-1:0]       r_iss_rs1, r_iss_rs2, r_iss_rd;
    logic [PAYLOAD_W-1:0] r_iss_payload;

    logic                 w_enq_ready, w_load, w_deq, w_found;
    logic [DW-1:0]        w_fire, w_in_rdy1, w_in_rdy2;
    logic [DEPTH-1:0]     w_wake1, w_wake2, w_elig, w_sel, w_new, w_free;
    logic [SW-1:0]        w_new_slot [DEPTH];
    logic [CW-1:0]        w_n_enq;
    logic [PRW-1:0]       w_sel_rs1, w_sel_rs2, w_sel_rd;
    logic [PAYLOAD_W-1:0] w_sel_payload;

    assign w_enq_ready = r_count <= CW'(DEPTH - DW);
    assign w_load      = ~r_iss_valid | iss_ready_i;
    assign w_deq       = w_load & (|w_elig);

    // Writeback tag match against resident sources and against sources arriving this cycle
    always_comb begin
        w_wake1   = '0;
        w_wake2   = '0;
        w_in_rdy1 = enq_rs1_rdy_i;
        w_in_rdy2 = enq_rs2_rdy_i;
        for (int k = 0; k < DW; k++) begin
            w_in_rdy1[k] = w_in_rdy1[k] | (enq_rs1_preg_i[k*PRW +: PRW] == '0);
            w_in_rdy2[k] = w_in_rdy2[k] | (enq_rs2_preg_i[k*PRW +: PRW] == '0);
        end
        for (int w = 0; w < WB_WIDTH; w++) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_wake1[i] = w_wake1[i] | (wb_valid_i[w] && wb_preg_i[w*PRW +: PRW] == r_rs1[i]);
                w_wake2[i] = w_wake2[i] | (wb_valid_i[w] && wb_preg_i[w*PRW +: PRW] == r_rs2[i]);
            end
            for (int k = 0; k < DW; k++) begin
                w_in_rdy1[k] = w_in_rdy1[k] | (wb_valid_i[w] && wb_preg_i[w*PRW +: PRW] == enq_rs1_preg_i[k*PRW +: PRW]);
                w_in_rdy2[k] = w_in_rdy2[k] | (wb_valid_i[w] && wb_preg_i[w*PRW +: PRW] == enq_rs2_preg_i[k*PRW +: PRW]);
            end
        end
    end

    // Valid slots take the lowest free entries in slot order; entries freed this cycle stay busy
    always_comb begin
        w_fire  = enq_valid_i & {DW{w_enq_ready}};
        w_free  = ~r_valid;
        w_new   = '0;
        w_n_enq = '0;
        w_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) w_new_slot[i] = '0;
        for (int k = 0; k < DW; k++) begin
            if (w_fire[k]) begin
                w_n_enq = w_n_enq + CW'(1);
                w_found = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_free[i] && !w_found) begin
                        w_found       = 1'b1;
                        w_free[i]     = 1'b0;
                        w_new[i]      = 1'b1;
                        w_new_slot[i] = SW'(k);
                    end
                end
            end
        end
    end

    // Oldest eligible entry: eligible and no other eligible entry is older than it
    always_comb begin
        w_elig        = r_valid & r_rs1_rdy & r_rs2_rdy;
        w_sel         = w_elig;
        w_sel_rs1     = '0;
        w_sel_rs2     = '0;
        w_sel_rd      = '0;
        w_sel_payload = '0;
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH; j++)
                if (w_elig[j] && r_older[j][i]) w_sel[i] = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel[i]) begin
                w_sel_rs1     = r_rs1[i];
                w_sel_rs2     = r_rs2[i];
                w_sel_rd      = r_rd[i];
                w_sel_payload = r_payload[i];
            end
        end
    end

    // Entry control: allocate, wake up, free on issue, and keep the age matrix ordered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid   <= '0;
            r_rs1_rdy <= '0;
            r_rs2_rdy <= '0;
            for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
        end else if (flush_i) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_new[i]) begin
                    r_valid[i]   <= 1'b1;
                    r_rs1_rdy[i] <= w_in_rdy1[w_new_slot[i]];
                    r_rs2_rdy[i] <= w_in_rdy2[w_new_slot[i]];
                    for (int j = 0; j < DEPTH; j++)
                        r_older[i][j] <= w_new[j] && (w_new_slot[i] < w_new_slot[j]);
                end else begin
                    if (w_deq && w_sel[i]) r_valid[i] <= 1'b0;
                    r_rs1_rdy[i] <= r_rs1_rdy[i] | w_wake1[i];
                    r_rs2_rdy[i] <= r_rs2_rdy[i] | w_wake2[i];
                    for (int j = 0; j < DEPTH; j++)
                        if (w_new[j]) r_older[i][j] <= 1'b1;
                end
            end
        end
    end

    // Entry payload storage, written only on allocation
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_new[i]) begin
                r_rs1[i]     <= enq_rs1_preg_i[PRW*int'(w_new_slot[i]) +: PRW];
                r_rs2[i]     <= enq_rs2_preg_i[PRW*int'(w_new_slot[i]) +: PRW];
                r_rd[i]      <= enq_rd_preg_i[PRW*int'(w_new_slot[i]) +: PRW];
                r_payload[i] <= enq_payload_i[PAYLOAD_W*int'(w_new_slot[i]) +: PAYLOAD_W];
            end
        end
    end

    // Occupancy count tracks enqueues minus issues
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_count <= '0;
        else if (flush_i) r_count <= '0;
        else r_count <= r_count + w_n_enq - CW'(w_deq);
    end

    // Registered issue stage; holds steady while stalled by execute
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_iss_valid   <= 1'b0;
            r_iss_rs1     <= '0;
            r_iss_rs2     <= '0;
            r_iss_rd      <= '0;
            r_iss_payload <= '0;
        end else if (flush_i) begin
            r_iss_valid <= 1'b0;
        end else if (w_load) begin
            r_iss_valid <= |w_elig;
            if (|w_elig) begin
                r_iss_rs1     <= w_sel_rs1;
                r_iss_rs2     <= w_sel_rs2;
                r_iss_rd      <= w_sel_rd;
                r_iss_payload <= w_sel_payload;
            end
        end
    end

    assign enq_ready_o    = w_enq_ready;
    assign iss_valid_o    = r_iss_valid;
    assign iss_rs1_preg_o = r_iss_rs1;
    assign iss_rs2_preg_o = r_iss_rs2;
    assign iss_rd_preg_o  = r_iss_rd;
    assign iss_payload_o  = r_iss_payload;
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed self-checking bench for issue_queue
module tb_issue_queue;
    localparam int DW  = 4;
    localparam int WB  = 4;
    localparam int PRW = 6;
    localparam int PW  = 64;

    logic              clk = 1'b0;
    logic              rst, flush, iss_ready, enq_ready, iss_valid;
    logic [DW-1:0]     enq_valid, enq_rs1_rdy, enq_rs2_rdy;
    logic [DW*PRW-1:0] enq_rs1, enq_rs2, enq_rd;
    logic [DW*PW-1:0]  enq_payload;
    logic [WB-1:0]     wb_valid;
    logic [WB*PRW-1:0] wb_preg;
    logic [PRW-1:0]    iss_rs1, iss_rs2, iss_rd;
    logic [PW-1:0]     iss_payload;
    int                n_checks = 0;
    int                n_err = 0;

    issue_queue dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .enq_valid_i(enq_valid), .enq_rs1_preg_i(enq_rs1), .enq_rs2_preg_i(enq_rs2),
        .enq_rd_preg_i(enq_rd), .enq_rs1_rdy_i(enq_rs1_rdy), .enq_rs2_rdy_i(enq_rs2_rdy),
        .enq_payload_i(enq_payload), .enq_ready_o(enq_ready),
        .wb_valid_i(wb_valid), .wb_preg_i(wb_preg),
        .iss_valid_o(iss_valid), .iss_ready_i(iss_ready),
        .iss_rs1_preg_o(iss_rs1), .iss_rs2_preg_o(iss_rs2), .iss_rd_preg_o(iss_rd),
        .iss_payload_o(iss_payload)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        enq_valid = '0; enq_rs1_rdy = '0; enq_rs2_rdy = '0;
        enq_rs1 = '0; enq_rs2 = '0; enq_rd = '0; enq_payload = '0;
        wb_valid = '0; wb_preg = '0; flush = 1'b0;
    endtask

    task automatic set_slot(input int k, input logic [PRW-1:0] rs1, input logic [PRW-1:0] rs2,
                            input logic [PRW-1:0] rd, input logic r1, input logic r2, input logic [PW-1:0] pl);
        enq_valid[k] = 1'b1;
        enq_rs1[k*PRW +: PRW] = rs1;
        enq_rs2[k*PRW +: PRW] = rs2;
        enq_rd[k*PRW +: PRW] = rd;
        enq_rs1_rdy[k] = r1;
        enq_rs2_rdy[k] = r2;
        enq_payload[k*PW +: PW] = pl;
    endtask

    task automatic set_wb(input int w, input logic [PRW-1:0] p);
        wb_valid[w] = 1'b1;
        wb_preg[w*PRW +: PRW] = p;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        iss_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", iss_valid, 0);
        chk("rst_payload", iss_payload, 0);
        chk("rst_rs1", iss_rs1, 0);
        chk("rst_enq_ready", enq_ready, 1);
        chk("rst_count", dut.r_count, 0);

        // single ready uop: issue two cycles after enqueue
        iss_ready = 1'b1;
        set_slot(0, 6'd5, 6'd6, 6'd7, 1'b1, 1'b1, 64'h11);
        step(); idle();
        chk("t1_not_yet", iss_valid, 0);
        chk("t1_count1", dut.r_count, 1);
        step();
        chk("t1_valid", iss_valid, 1);
        chk("t1_rs1", iss_rs1, 5);
        chk("t1_rs2", iss_rs2, 6);
        chk("t1_rd", iss_rd, 7);
        chk("t1_payload", iss_payload, 64'h11);
        chk("t1_count0", dut.r_count, 0);
        step();
        chk("t1_empty", iss_valid, 0);

        // younger ready uop bypasses an older waiting one
        set_slot(0, 6'd7, 6'd8, 6'd9, 1'b0, 1'b1, 64'hA);
        step(); idle();
        set_slot(0, 6'd10, 6'd11, 6'd12, 1'b1, 1'b1, 64'hB);
        step(); idle();
        chk("t2_a_waits", iss_valid, 0);
        set_wb(0, 6'd7);
        step(); idle();
        chk("t2_b_first", iss_payload, 64'hB);
        chk("t2_b_valid", iss_valid, 1);
        step();
        chk("t2_a_second", iss_payload, 64'hA);
        chk("t2_a_rs1", iss_rs1, 7);
        step();
        chk("t2_empty", iss_valid, 0);

        // same-cycle wakeup, preg 0 always ready, wakeup of an absent preg
        set_slot(0, 6'd9, 6'd3, 6'd1, 1'b0, 1'b1, 64'h39);
        set_slot(1, 6'd0, 6'd0, 6'd2, 1'b0, 1'b0, 64'h3B);
        set_slot(2, 6'd11, 6'd4, 6'd3, 1'b0, 1'b1, 64'h3C);
        set_wb(0, 6'd9);
        step(); idle();
        set_wb(1, 6'd12);
        step(); idle();
        chk("t3_same_cycle_wake", iss_payload, 64'h39);
        step();
        chk("t3_preg0", iss_payload, 64'h3B);
        step();
        chk("t3_no_spurious", iss_valid, 0);
        set_wb(2, 6'd11);
        step(); idle();
        chk("t3_wake_not_visible", iss_valid, 0);
        step();
        chk("t3_woken", iss_payload, 64'h3C);
        chk("t3_woken_valid", iss_valid, 1);
        step();
        chk("t3_empty", iss_valid, 0);

        // fill while stalled, full backpressure, stable hold, ordered drain
        iss_ready = 1'b0;
        for (int g = 1; g <= 4; g++) begin
            for (int k = 0; k < DW; k++)
                set_slot(k, PRW'(20 + k), 6'd21, PRW'(30 + k), 1'b1, 1'b1, 64'(g * 256 + k));
            step(); idle();
            if (g == 1) chk("t4_g1_valid", iss_valid, 0);
            if (g == 2) chk("t4_g2_head", iss_payload, 64'h100);
            if (g == 3) chk("t4_g3_ready", enq_ready, 1);
            if (g == 3) chk("t4_g3_count", dut.r_count, 11);
            if (g == 4) chk("t4_full_ready", enq_ready, 0);
            if (g == 4) chk("t4_full_count", dut.r_count, 15);
        end
        for (int k = 0; k < DW; k++)
            set_slot(k, 6'd1, 6'd1, 6'd1, 1'b1, 1'b1, 64'(16'h500 + k));
        step(); idle();
        chk("t4_ignored_count", dut.r_count, 15);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t4_hold_valid", iss_valid, 1);
            chk("t4_hold_payload", iss_payload, 64'h100);
        end
        iss_ready = 1'b1;
        for (int g = 1; g <= 4; g++) begin
            for (int k = (g == 1) ? 1 : 0; k < DW; k++) begin
                step();
                chk("t4_drain", iss_payload, 64'(g * 256 + k));
            end
        end
        step();
        chk("t4_drained_valid", iss_valid, 0);
        chk("t4_drained_count", dut.r_count, 0);

        // age order beats entry index; slot order within a group with holes
        set_slot(0, 6'd1, 6'd2, 6'd3, 1'b1, 1'b1, 64'h90);
        set_slot(1, 6'd30, 6'd2, 6'd4, 1'b0, 1'b1, 64'h91);
        step(); idle();
        step();
        chk("t5_p", iss_payload, 64'h90);
        set_slot(0, 6'd30, 6'd2, 6'd5, 1'b0, 1'b1, 64'hA0);
        set_slot(2, 6'd30, 6'd2, 6'd6, 1'b0, 1'b1, 64'hA2);
        set_slot(3, 6'd30, 6'd2, 6'd7, 1'b0, 1'b1, 64'hA3);
        step(); idle();
        chk("t5_wait", iss_valid, 0);
        set_wb(3, 6'd30);
        step(); idle();
        chk("t5_wait2", iss_valid, 0);
        step();
        chk("t5_oldest", iss_payload, 64'h91);
        step();
        chk("t5_slot0", iss_payload, 64'hA0);
        step();
        chk("t5_slot2", iss_payload, 64'hA2);
        step();
        chk("t5_slot3", iss_payload, 64'hA3);
        step();
        chk("t5_empty", iss_valid, 0);

        // flush dominates enqueue and handshake
        iss_ready = 1'b0;
        for (int k = 0; k < DW; k++) set_slot(k, 6'd1, 6'd1, 6'd1, 1'b1, 1'b1, 64'(8'hC0 + k));
        step(); idle();
        for (int k = 0; k < DW; k++) set_slot(k, 6'd1, 6'd1, 6'd1, 1'b1, 1'b1, 64'(8'hD0 + k));
        step(); idle();
        set_slot(0, 6'd1, 6'd1, 6'd1, 1'b1, 1'b1, 64'hE0);
        step(); idle();
        chk("t6_count8", dut.r_count, 8);
        chk("t6_head", iss_payload, 64'hC0);
        flush = 1'b1;
        iss_ready = 1'b1;
        for (int k = 0; k < DW; k++) set_slot(k, 6'd1, 6'd1, 6'd1, 1'b1, 1'b1, 64'(8'hF0 + k));
        step(); idle();
        chk("t6_valid", iss_valid, 0);
        chk("t6_count", dut.r_count, 0);
        chk("t6_enq_ready", enq_ready, 1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t6_no_issue", iss_valid, 0);
        end

        // asynchronous reset while stalled
        iss_ready = 1'b0;
        set_slot(0, 6'd1, 6'd1, 6'd1, 1'b1, 1'b1, 64'h77);
        set_slot(1, 6'd1, 6'd1, 6'd1, 1'b1, 1'b1, 64'h78);
        step(); idle();
        step();
        chk("t7_pre", iss_payload, 64'h77);
        #2 rst = 1'b1;
        #1;
        chk("t7_async_valid", iss_valid, 0);
        chk("t7_async_payload", iss_payload, 0);
        chk("t7_async_count", dut.r_count, 0);
        #2 rst = 1'b0;
        step();
        chk("t7_after_valid", iss_valid, 0);
        chk("t7_after_ready", enq_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
